// File: rtl/sm4_key_expander.sv
// sm4_key_expander: SM4 key schedule, one round per cycle, with a registered round-key read port
// Ports: clk_i/reset_i (async, active-high) clock and reset; key_v_i/key_i/key_ready_o master-key handshake
// (key_i[127:96]=MK0); rk_valid_o marks a complete schedule; rk_idx_i/rk_o read rk[idx] one cycle later.
package sm4_encryptor_pkg;
  localparam int word_width_p = 32;
  localparam int group_size_p = 128;
endpackage

// turn_transform: one SM4 round, o = X0 ^ T(X1^X2^X3^rkey), linear layer chosen by is_key_i
module turn_transform #(
  parameter int word_width_p = sm4_encryptor_pkg::word_width_p,
  parameter int group_size_p = sm4_encryptor_pkg::group_size_p
) (
  input  logic [group_size_p-1:0] i,
  input  logic                    is_key_i,
  input  logic [word_width_p-1:0] rkey_i,
  input  logic [word_width_p-1:0] mask_i,
  output logic [word_width_p-1:0] o,
  output logic [word_width_p-1:0] mask_o
);
  localparam logic [7:0] sbox_t [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };
  logic [31:0] x, b, l;
  always_comb begin
    x = i[63:32] ^ i[95:64] ^ i[127:96] ^ rkey_i;
    for (int k = 0; k < 4; k++) b[8*k +: 8] = sbox_t[x[8*k +: 8]];
    l = is_key_i ? b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]}
                 : b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]} ^ {b[13:0], b[31:14]} ^ {b[7:0], b[31:8]};
  end
  assign o = i[31:0] ^ l;
  // masking only applies to the data path; the mask is forwarded unchanged
  assign mask_o = mask_i;
endmodule

module sm4_key_expander #(
  parameter int rounds_p     = 32,
  parameter int word_width_p = sm4_encryptor_pkg::word_width_p,
  parameter int group_size_p = sm4_encryptor_pkg::group_size_p
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    key_v_i,
  input  logic [group_size_p-1:0] key_i,
  output logic                    key_ready_o,
  output logic                    rk_valid_o,
  input  logic [4:0]              rk_idx_i,
  output logic [word_width_p-1:0] rk_o
);
  localparam logic [31:0] fk0 = 32'hA3B1BAC6, fk1 = 32'h56AA3350, fk2 = 32'h677D9197, fk3 = 32'hB27022DC;
  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;
  state_t state, state_n;
  logic [4:0] r;
  logic [group_size_p-1:0] s;
  logic [word_width_p-1:0] rk_buf [rounds_p];
  logic [word_width_p-1:0] ck, o, mask_unused;
  logic [7:0] ck_base;
  logic accept, last;
  // CK byte j = 7*(4r+j) mod 256, i.e. 28r + 7j with 8-bit wrap
  assign ck_base = 8'(r) * 8'd28;
  assign ck = {ck_base, ck_base + 8'd7, ck_base + 8'd14, ck_base + 8'd21};
  assign accept = key_v_i & key_ready_o;
  assign last = (state == EXPAND) && (r == 5'(rounds_p - 1));
  always_comb begin
    key_ready_o = state != EXPAND;
    rk_valid_o = state == DONE;
    state_n = accept ? EXPAND : last ? DONE : state;
  end
  turn_transform u_tt (
    .i(s), .is_key_i(1'b1), .rkey_i(ck), .mask_i('0), .o(o), .mask_o(mask_unused)
  );
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state <= IDLE;
      s <= '0;
      r <= '0;
      rk_o <= '0;
    end else begin
      state <= state_n;
      rk_o <= rk_buf[rk_idx_i];
      if (accept) begin
        s <= {key_i[31:0] ^ fk3, key_i[63:32] ^ fk2, key_i[95:64] ^ fk1, key_i[127:96] ^ fk0};
        r <= '0;
      end else if (state == EXPAND) begin
        s <= {o, s[127:32]};
        r <= r + 5'd1;
      end
    end
  end
  always_ff @(posedge clk_i)
    if (state == EXPAND) rk_buf[r] <= o;
endmodule

// File: tb/tb_sm4_key_expander.sv
// tb_sm4_key_expander: randomized self-checking bench against a word-list model of the SM4 key schedule
module tb_sm4_key_expander;
  logic clk = 0, reset_i, key_v_i, key_ready_o, rk_valid_o;
  logic [127:0] key_i;
  logic [4:0] rk_idx_i;
  logic [31:0] rk_o;
  int checks = 0, errors = 0;
  logic [31:0] exp_rk [32];
  logic [31:0] exp_a [32];
  localparam logic [7:0] sbox [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  always #5 clk = ~clk;

  sm4_key_expander dut (
    .clk_i(clk), .reset_i(reset_i), .key_v_i(key_v_i), .key_i(key_i),
    .key_ready_o(key_ready_o), .rk_valid_o(rk_valid_o), .rk_idx_i(rk_idx_i), .rk_o(rk_o)
  );

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [31:0] tprime(input logic [31:0] x);
    logic [31:0] b;
    for (int j = 0; j < 4; j++) b[8*j +: 8] = sbox[x[8*j +: 8]];
    return b ^ rotl(b, 13) ^ rotl(b, 23);
  endfunction

  function automatic logic [31:0] ck_of(input int n);
    logic [31:0] c;
    for (int j = 0; j < 4; j++) c[31 - 8*j -: 8] = 8'(((4 * n + j) * 7) % 256);
    return c;
  endfunction

  task automatic model(input logic [127:0] mk);
    logic [31:0] k [36];
    k[0] = mk[127:96] ^ 32'hA3B1BAC6;
    k[1] = mk[95:64]  ^ 32'h56AA3350;
    k[2] = mk[63:32]  ^ 32'h677D9197;
    k[3] = mk[31:0]   ^ 32'hB27022DC;
    for (int n = 0; n < 32; n++) begin
      k[n + 4] = k[n] ^ tprime(k[n + 1] ^ k[n + 2] ^ k[n + 3] ^ ck_of(n));
      exp_rk[n] = k[n + 4];
    end
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic accept_key(input logic [127:0] k);
    key_i = k;
    key_v_i = 1;
    @(posedge clk); #1;
    key_v_i = 0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!rk_valid_o && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset();
    reset_i = 1; key_v_i = 1; key_i = rand_key(); rk_idx_i = 0;
    @(posedge clk); #1;
    checks++; if (key_ready_o !== 1'b1) begin errors++; $display("FAIL reset_key_ready: got %b expected 1", key_ready_o); end
    checks++; if (rk_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rk_valid: got %b expected 0", rk_valid_o); end
    checks++; if (rk_o !== 32'h0) begin errors++; $display("FAIL reset_rk_o: got %h expected 00000000", rk_o); end
    reset_i = 0; key_v_i = 0;
    @(posedge clk); #1;
    checks++; if (key_ready_o !== 1'b1) begin errors++; $display("FAIL no_accept_in_reset: got key_ready %b expected 1", key_ready_o); end
  endtask

  task automatic test_standard();
    int n;
    logic [31:0] got [32];
    logic [31:0] exp_ck;
    model(128'h0123456789ABCDEFFEDCBA9876543210);
    accept_key(128'h0123456789ABCDEFFEDCBA9876543210);
    n = 0;
    while (!rk_valid_o && n < 40) begin
      if (n == 0 || n == 1 || n == 31) begin
        exp_ck = n == 0 ? 32'h00070E15 : n == 1 ? 32'h1C232A31 : 32'h646B7279;
        checks++;
        if (dut.u_tt.rkey_i !== exp_ck) begin errors++; $display("FAIL ck_r%0d: got %h expected %h", n, dut.u_tt.rkey_i, exp_ck); end
      end
      @(posedge clk); #1;
      n++;
    end
    checks++; if (n !== 32) begin errors++; $display("FAIL std_latency: got %0d expected 32", n); end
    for (int i = 0; i < 32; i++) begin
      rk_idx_i = 5'(i);
      @(posedge clk); #1;
      got[i] = rk_o;
    end
    checks++; if (got[0] !== 32'hF12186F9) begin errors++; $display("FAIL std_rk0: got %h expected F12186F9", got[0]); end
    checks++; if (got[1] !== 32'h41662B61) begin errors++; $display("FAIL std_rk1: got %h expected 41662B61", got[1]); end
    checks++; if (got[31] !== 32'h9124A012) begin errors++; $display("FAIL std_rk31: got %h expected 9124A012", got[31]); end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (got[i] !== exp_rk[i]) begin errors++; $display("FAIL std_model_rk%0d: got %h expected %h", i, got[i], exp_rk[i]); end
    end
  endtask

  task automatic test_reverse_sweep();
    rk_idx_i = 5'd31;
    for (int k = 31; k >= 0; k--) begin
      @(posedge clk); #1;
      checks++;
      if (rk_o !== exp_rk[k]) begin errors++; $display("FAIL reverse_rk%0d: got %h expected %h", k, rk_o, exp_rk[k]); end
      rk_idx_i = 5'(k - 1);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    accept_key(128'h0);
    checks++; if (rk_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_valid_drop: got %b expected 0", rk_valid_o); end
    checks++; if (key_ready_o !== 1'b0) begin errors++; $display("FAIL b2b_ready_drop: got %b expected 0", key_ready_o); end
    wait_valid(n);
    checks++; if (n !== 32) begin errors++; $display("FAIL b2b_latency: got %0d expected 32", n); end
    model(128'h0);
    for (int i = 0; i < 32; i++) begin
      rk_idx_i = 5'(i);
      @(posedge clk); #1;
      checks++;
      if (rk_o !== exp_rk[i]) begin errors++; $display("FAIL b2b_rk%0d: got %h expected %h", i, rk_o, exp_rk[i]); end
    end
  endtask

  task automatic test_hold_during_expand();
    logic [127:0] a, b;
    int n, bad;
    a = rand_key();
    b = rand_key();
    model(a);
    exp_a = exp_rk;
    accept_key(a);
    key_i = b;
    key_v_i = 1;
    n = 0; bad = 0;
    while (!rk_valid_o && n < 40) begin
      if (key_ready_o !== 1'b0) bad++;
      @(posedge clk); #1;
      n++;
    end
    checks++; if (n !== 32) begin errors++; $display("FAIL hold_latency: got %0d expected 32", n); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL hold_ready_in_expand: got %0d ready cycles expected 0", bad); end
    rk_idx_i = 0;
    // each index is read one edge before the new schedule overwrites it
    for (int j = 1; j <= 32; j++) begin
      @(posedge clk); #1;
      if (j == 1) begin
        key_v_i = 0;
        checks++; if (key_ready_o !== 1'b0) begin errors++; $display("FAIL hold_second_accept: got ready %b expected 0", key_ready_o); end
      end
      checks++;
      if (rk_o !== exp_a[j - 1]) begin errors++; $display("FAIL hold_first_rk%0d: got %h expected %h", j - 1, rk_o, exp_a[j - 1]); end
      rk_idx_i = 5'(j);
    end
    wait_valid(n);
    checks++; if (n !== 1) begin errors++; $display("FAIL hold_second_latency: got %0d extra cycles expected 1", n); end
    model(b);
    for (int i = 0; i < 32; i++) begin
      rk_idx_i = 5'(i);
      @(posedge clk); #1;
      checks++;
      if (rk_o !== exp_rk[i]) begin errors++; $display("FAIL hold_second_rk%0d: got %h expected %h", i, rk_o, exp_rk[i]); end
    end
  endtask

  task automatic test_reset_mid_expand();
    logic [127:0] c;
    int n;
    accept_key(rand_key());
    repeat (17) begin @(posedge clk); #1; end
    #2 reset_i = 1;
    #1;
    checks++; if (key_ready_o !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b expected 1", key_ready_o); end
    checks++; if (rk_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", rk_valid_o); end
    checks++; if (rk_o !== 32'h0) begin errors++; $display("FAIL midrst_rk_o: got %h expected 00000000", rk_o); end
    @(posedge clk); #1;
    reset_i = 0;
    n = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (rk_valid_o !== 1'b0) n++;
    end
    checks++; if (n !== 0) begin errors++; $display("FAIL midrst_stays_invalid: got %0d valid cycles expected 0", n); end
    c = rand_key();
    model(c);
    accept_key(c);
    wait_valid(n);
    checks++; if (n !== 32) begin errors++; $display("FAIL midrst_latency: got %0d expected 32", n); end
    for (int i = 0; i < 32; i++) begin
      rk_idx_i = 5'(i);
      @(posedge clk); #1;
      checks++;
      if (rk_o !== exp_rk[i]) begin errors++; $display("FAIL midrst_rk%0d: got %h expected %h", i, rk_o, exp_rk[i]); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_standard();
    test_reverse_sweep();
    test_back_to_back();
    test_hold_during_expand();
    test_reset_mid_expand();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sm4_key_expander.md
Name: sm4_key_expander

Overview:
- Upstream stage of the SM4 round datapath.
- Accepts a 128-bit master key MK and runs the 32-round SM4 key schedule, one round per cycle, through one turn_transform instance with is_key_i=1.
- Stores rk0..rk31 in an internal buffer.
- Serves round keys to the encrypt/decrypt round engine through an indexed, registered read port. Decryption simply reads indices in reverse.

Parameters:
- rounds_p, 32, number of key-schedule rounds and buffer depth. Fixed by SM4; other values are unsupported.
- word_width_p, from sm4_encryptor_pkg (32), round-key width.
- group_size_p, from sm4_encryptor_pkg (128), master-key width.

Ports:
- clk_i  input  1  clock.
- reset_i  input  1  asynchronous, active-high reset.
- key_v_i  input  1  master key valid.
- key_i  input  128  master key. key_i[127:96] is MK0 and key_i[31:0] is MK3.
- key_ready_o  output  1  expander can accept a key.
- rk_valid_o  output  1  buffer holds a complete schedule for the last accepted key.
- rk_idx_i  input  5  round-key read index.
- rk_o  output  32  registered read data, equal to buf[rk_idx_i] from the previous cycle.

Behaviour:
- Reset is asynchronous, active-high, on clk_i.
  - Reset values: state=IDLE, key_ready_o=1, rk_valid_o=0, rk_o=0, round counter=0, state register=0.
  - Buffer contents are not reset and are don't-care while rk_valid_o=0.
- FSM states are IDLE, EXPAND and DONE.
  - IDLE: key_ready_o=1. On key_v_i&key_ready_o, go to EXPAND.
  - EXPAND: key_ready_o=0. Runs 32 rounds. After round 31 is written, go to DONE.
  - DONE: key_ready_o=1, rk_valid_o=1. On key_v_i, go to EXPAND.
- Key capture (the accept cycle): load state S, with S[127:96]=K3, S[95:64]=K2, S[63:32]=K1, S[31:0]=K0.
  - Kj = MKj ^ FKj.
  - FK0=A3B1BAC6, FK1=56AA3350, FK2=677D9197, FK3=B27022DC.
  - Set round counter r=0 and rk_valid_o=0 on the next edge.
- EXPAND, each cycle with r=0..31:
  - Drive turn_transform with i=S, is_key_i=1, rkey_i=CK_r, mask_i=0. mask_o is unused; the key path is unmasked.
  - Write buf[r] <= o.
  - Update S <= {o, S[127:32]}.
  - Increment r. On r=31, go to DONE and set rk_valid_o=1 on that same edge.
- Latency: rk_valid_o rises exactly 32 cycles after the accept edge.
- CK_r generation:
  - Byte j of CK_r, with j=0 the MSB byte, is ((4r+j)*7) mod 256.
  - Computed arithmetically from r with 8-bit wrap, or from an equivalent 32-entry constant table.
- Read port:
  - rk_o <= buf[rk_idx_i] every cycle, regardless of state.
  - The consumer must only trust rk_o while rk_valid_o was 1 on the cycle the index was presented.
  - Reading an index written in the same cycle returns the old content. No bypass.
- Boundary conditions:
  - key_v_i during EXPAND is ignored (key_ready_o=0). The upstream must hold key_v_i until accepted.
  - A new key accepted in DONE drops rk_valid_o on the next edge and overwrites the buffer progressively.
  - Reset mid-EXPAND aborts immediately: state=IDLE, rk_valid_o=0. A partial schedule is never flagged valid.
  - key_v_i asserted in the same cycle reset_i deasserts is not accepted. Acceptance requires reset low at the clock edge.

Test Plan:
- Standard vector: key_i=0123456789ABCDEFFEDCBA9876543210 -> rk_valid_o high 32 cycles after accept; rk0=F12186F9, rk1=41662B61, rk31=9124A012.
- CK check, probing rkey_i: r=0 -> 00070E15; r=1 -> 1C232A31; r=31 -> 646B7279.
- Back-to-back keys: accept key A, wait for DONE, accept key B (all-zero key) -> rk_valid_o drops one cycle after accept and returns after 32 cycles; the buffer matches the software model for B, with no residue from A.
- key_v_i held during EXPAND with a different key -> ignored; the schedule matches the first key; the second key is accepted only once DONE is reached.
- Assert reset_i asynchronously at round 17 -> outputs return to reset values without a clock edge; rk_valid_o stays 0; a fresh key then expands correctly.
- Reverse read sweep: rk_idx_i=31..0 on consecutive cycles in DONE -> rk_o shows buf[idx] one cycle later, in decryption order.
